exposure_sequencer: RTL and testbench
=====================================

// Module: exposure_sequencer
// PURPOSE
//  Counter-based phase scheduler for the sensor timing path. On a start pulse it runs
//  N frames. Each frame is EXPOSE -> READOUT -> GAP, and each phase lasts a programmed
//  number of clk cycles. It drives the expose/readout enables consumed by the pixel
//  pattern and readout logic, and reports per-frame and end-of-sequence pulses.
// PARAMETERS
//  CNT_W    16  width of phase duration configs and of the phase counter
//  FRAME_W  8   width of frame-count config and of the completed-frame counter
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  rst_n        in   1        asynchronous active-low reset
//  start        in   1        1-cycle request to begin a sequence (honoured only in IDLE)
//  abort        in   1        terminate the running sequence immediately
//  cfg_expose   in   CNT_W    EXPOSE duration in cycles (0 treated as 1)
//  cfg_readout  in   CNT_W    READOUT duration in cycles (0 treated as 1)
//  cfg_gap      in   CNT_W    GAP duration in cycles (0 treated as 1)
//  cfg_frames   in   FRAME_W  frames per sequence; 0 = continuous until abort
//  busy         out  1        high whenever state != IDLE
//  phase        out  2        0 IDLE, 1 EXPOSE, 2 READOUT, 3 GAP
//  expose_en    out  1        high exactly while phase==EXPOSE
//  readout_en   out  1        high exactly while phase==READOUT
//  phase_cnt    out  CNT_W    cycles elapsed in current phase, 0-based
//  frame_cnt    out  FRAME_W  completed frames since last start
//  frame_done   out  1        1-cycle pulse on the last GAP cycle of each frame
//  seq_done     out  1        1-cycle pulse on the last GAP cycle of the final frame
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE. All outputs 0, including phase_cnt
//    and frame_cnt.
//  - IDLE: start=1 && abort=0 at edge t does the following:
//    latch all cfg_* into shadow registers, clear frame_cnt and phase_cnt,
//    enter EXPOSE at t+1 (1-cycle latency).
//  - cfg_* are sampled only at start. Changes while busy have no effect.
//  - Every phase X lasts D=max(cfg_X,1) cycles. phase_cnt runs 0..D-1.
//  - When phase_cnt==D-1, the next cycle enters the next phase with phase_cnt=0.
//  - Transitions: EXPOSE->READOUT->GAP. On the last GAP cycle:
//    frame_done=1 and frame_cnt increments on that edge.
//    If cfg_frames!=0 and frame_cnt+1==cfg_frames: seq_done=1, next state IDLE.
//    Otherwise next state is EXPOSE.
//  - Continuous mode (cfg_frames=0): seq_done never asserts. frame_cnt wraps modulo
//    2^FRAME_W (max -> 0) with no other effect.
//  - start while busy: ignored, with no restart and no counter clear.
//  - abort=1 in any non-IDLE state: next cycle IDLE, phase_cnt=0, enables low,
//    frame_cnt held.
//    If the abort cycle is the last GAP cycle, frame_done/seq_done are suppressed
//    and frame_cnt is not incremented.
//  - abort and start in the same IDLE cycle: abort wins and the block stays IDLE.
//  - expose_en, readout_en and phase are decoded from the state register only, so
//    they are glitch-free. frame_done and seq_done are decoded from state+phase_cnt,
//    with no extra latency.
//  - Phase_cnt comparison is done at CNT_W bits. D=2^CNT_W-1 is the maximum duration,
//    and no overflow is possible.
// TESTING
//  1 E=3,R=2,G=1,frames=2, start@0 -> result:
//    expose_en cycles 1-3 and 7-9, readout_en 4-5 and 10-11.
//    frame_done @6 and @12, seq_done @12 only, busy low @13, frame_cnt=2.
//  2 All cfg=0, frames=1, start@0 -> EXPOSE@1, READOUT@2, GAP@3 with
//    frame_done=seq_done=1 @3, IDLE @4.
//  3 E=5,R=5,G=5,frames=0, abort at READOUT phase_cnt=2 -> next cycle:
//    phase=0, busy=0, enables 0, frame_cnt held, no frame_done.
//  4 frames=3 running; cfg_expose changed and start pulsed mid-EXPOSE -> timing is
//    unchanged from the latched values and frame_cnt is not cleared.
//  5 Continuous E=R=G=1, FRAME_W=8 -> 256 frame_done pulses, frame_cnt wraps
//    255->0, busy stays 1.
//  6 rst_n low mid-GAP (async, between edges) -> all outputs 0 immediately.
//    After release, start works normally.

Source files
------------

// File: rtl/exposure_sequencer.sv
// exposure_sequencer: counter-based EXPOSE -> READOUT -> GAP scheduler for the
// sensor timing path. A start pulse in IDLE latches the phase durations and frame
// count, then runs that many frames (or runs continuously until abort when the
// frame count is 0).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle sequence request, honoured only in IDLE
//   abort               return to IDLE on the next edge from any busy state
//   cfg_expose/readout/gap  phase durations in cycles (0 behaves as 1)
//   cfg_frames          frames per sequence, 0 = continuous
//   busy                high whenever not IDLE
//   phase               0 IDLE, 1 EXPOSE, 2 READOUT, 3 GAP
//   expose_en/readout_en    phase enables, decoded from the state register
//   phase_cnt           0-based cycle count within the current phase
//   frame_cnt           completed frames since the last start
//   frame_done          pulse on the last GAP cycle of every frame
//   seq_done            pulse on the last GAP cycle of the final frame
module exposure_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cfg_expose,
  input  logic [CNT_W-1:0]   cfg_readout,
  input  logic [CNT_W-1:0]   cfg_gap,
  input  logic [FRAME_W-1:0] cfg_frames,
  output logic               busy,
  output logic [1:0]         phase,
  output logic               expose_en,
  output logic               readout_en,
  output logic [CNT_W-1:0]   phase_cnt,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               frame_done,
  output logic               seq_done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXPOSE  = 2'd1,
    ST_READOUT = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  // Shadow registers hold the terminal phase_cnt value (D-1) rather than D,
  // so a zero duration maps naturally onto a single-cycle phase.
  logic [CNT_W-1:0]   last_expose_q, last_expose_d;
  logic [CNT_W-1:0]   last_readout_q, last_readout_d;
  logic [CNT_W-1:0]   last_gap_q, last_gap_d;
  logic [FRAME_W-1:0] frames_q, frames_d;

  logic phase_last;
  logic frame_end;
  logic seq_end;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      phase_cnt_q    <= '0;
      frame_cnt_q    <= '0;
      last_expose_q  <= '0;
      last_readout_q <= '0;
      last_gap_q     <= '0;
      frames_q       <= '0;
    end else begin
      state_q        <= state_d;
      phase_cnt_q    <= phase_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      last_expose_q  <= last_expose_d;
      last_readout_q <= last_readout_d;
      last_gap_q     <= last_gap_d;
      frames_q       <= frames_d;
    end
  end

  // Terminal-cycle detection for the current phase
  always_comb begin
    phase_last = 1'b0;
    unique case (state_q)
      ST_EXPOSE:  phase_last = (phase_cnt_q == last_expose_q);
      ST_READOUT: phase_last = (phase_cnt_q == last_readout_q);
      ST_GAP:     phase_last = (phase_cnt_q == last_gap_q);
      default:    phase_last = 1'b0;
    endcase
  end

  // An abort on the last GAP cycle swallows the frame completion entirely.
  assign frame_end = (state_q == ST_GAP) && phase_last && !abort;
  assign seq_end   = frame_end && (frames_q != '0) &&
                     (FRAME_W'(frame_cnt_q + FRAME_W'(1)) == frames_q);

  // Next-state and counter update
  always_comb begin
    state_d        = state_q;
    phase_cnt_d    = phase_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    last_expose_d  = last_expose_q;
    last_readout_d = last_readout_q;
    last_gap_d     = last_gap_q;
    frames_d       = frames_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          last_expose_d  = (cfg_expose  == '0) ? '0 : CNT_W'(cfg_expose  - CNT_W'(1));
          last_readout_d = (cfg_readout == '0) ? '0 : CNT_W'(cfg_readout - CNT_W'(1));
          last_gap_d     = (cfg_gap     == '0) ? '0 : CNT_W'(cfg_gap     - CNT_W'(1));
          frames_d       = cfg_frames;
          frame_cnt_d    = '0;
          phase_cnt_d    = '0;
          state_d        = ST_EXPOSE;
        end
      end
      default: begin
        if (abort) begin
          state_d     = ST_IDLE;
          phase_cnt_d = '0;
        end else if (phase_last) begin
          phase_cnt_d = '0;
          unique case (state_q)
            ST_EXPOSE:  state_d = ST_READOUT;
            ST_READOUT: state_d = ST_GAP;
            default: begin
              // Wraps modulo 2^FRAME_W in continuous mode.
              frame_cnt_d = FRAME_W'(frame_cnt_q + FRAME_W'(1));
              state_d     = seq_end ? ST_IDLE : ST_EXPOSE;
            end
          endcase
        end else begin
          phase_cnt_d = CNT_W'(phase_cnt_q + CNT_W'(1));
        end
      end
    endcase
  end

  // Output decode straight from registered state
  assign busy       = (state_q != ST_IDLE);
  assign phase      = state_q;
  assign expose_en  = (state_q == ST_EXPOSE);
  assign readout_en = (state_q == ST_READOUT);
  assign phase_cnt  = phase_cnt_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_end;
  assign seq_done   = seq_end;

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer; cycle k is sampled 1 time unit after
// the k-th rising edge following the start edge.
module tb_exposure_sequencer;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned FRAME_W = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   cfg_expose;
  logic [CNT_W-1:0]   cfg_readout;
  logic [CNT_W-1:0]   cfg_gap;
  logic [FRAME_W-1:0] cfg_frames;
  logic               busy;
  logic [1:0]         phase;
  logic               expose_en;
  logic               readout_en;
  logic [CNT_W-1:0]   phase_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               frame_done;
  logic               seq_done;

  int n_checks = 0;
  int n_errors = 0;

  exposure_sequencer #(.CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_expose (cfg_expose),
    .cfg_readout(cfg_readout),
    .cfg_gap    (cfg_gap),
    .cfg_frames (cfg_frames),
    .busy       (busy),
    .phase      (phase),
    .expose_en  (expose_en),
    .readout_en (readout_en),
    .phase_cnt  (phase_cnt),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done),
    .seq_done   (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int e, input int r, input int g, input int f);
    cfg_expose  = CNT_W'(e);
    cfg_readout = CNT_W'(r);
    cfg_gap     = CNT_W'(g);
    cfg_frames  = FRAME_W'(f);
  endtask

  // Start pulse on the next edge; returns sampling cycle 1.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_idle(input string pre);
    chk({pre, " busy"},      32'(busy),       0);
    chk({pre, " phase"},     32'(phase),      0);
    chk({pre, " expose"},    32'(expose_en),  0);
    chk({pre, " readout"},   32'(readout_en), 0);
    chk({pre, " phase_cnt"}, 32'(phase_cnt),  0);
    chk({pre, " fdone"},     32'(frame_done), 0);
    chk({pre, " sdone"},     32'(seq_done),   0);
  endtask

  // All-zero durations, one frame: EXPOSE@1 READOUT@2 GAP@3 IDLE@4.
  task automatic run_zero_cfg(input string pre);
    logic [1:0] exp_ph [4];
    exp_ph[0] = 2'd1; exp_ph[1] = 2'd2; exp_ph[2] = 2'd3; exp_ph[3] = 2'd0;
    cfg(0, 0, 0, 1);
    kick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("%s phase c%0d", pre, k), 32'(phase), 32'(exp_ph[k-1]));
      chk($sformatf("%s fdone c%0d", pre, k), 32'(frame_done), (k == 3) ? 1 : 0);
      chk($sformatf("%s sdone c%0d", pre, k), 32'(seq_done), (k == 3) ? 1 : 0);
      if (k < 4) step();
    end
    chk({pre, " frame_cnt"}, 32'(frame_cnt), 1);
  endtask

  initial begin
    int fd_count;
    int busy_drop;
    int fc_last;
    int m;
    int exp_ph;
    int exp_pc;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset frame_cnt", 32'(frame_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: E=3 R=2 G=1, two frames
    cfg(3, 2, 1, 2);
    kick();
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("t1 expose c%0d", k), 32'(expose_en),
          ((k >= 1 && k <= 3) || (k >= 7 && k <= 9)) ? 1 : 0);
      chk($sformatf("t1 readout c%0d", k), 32'(readout_en),
          ((k >= 4 && k <= 5) || (k >= 10 && k <= 11)) ? 1 : 0);
      chk($sformatf("t1 fdone c%0d", k), 32'(frame_done), (k == 6 || k == 12) ? 1 : 0);
      chk($sformatf("t1 sdone c%0d", k), 32'(seq_done), (k == 12) ? 1 : 0);
      chk($sformatf("t1 busy c%0d", k), 32'(busy), (k <= 12) ? 1 : 0);
      if (k < 13) step();
    end
    chk("t1 frame_cnt", 32'(frame_cnt), 2);
    chk("t1 phase_cnt", 32'(phase_cnt), 0);

    // 2: zero durations treated as one cycle
    step();
    run_zero_cfg("t2");

    // abort and start together in IDLE: abort wins
    step();
    cfg(3, 3, 3, 1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_idle("start+abort");

    // 3: abort at READOUT phase_cnt=2
    cfg(5, 5, 5, 0);
    kick();
    repeat (7) step();
    chk("t3 pre phase", 32'(phase), 2);
    chk("t3 pre phase_cnt", 32'(phase_cnt), 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("t3 post");
    chk("t3 post frame_cnt", 32'(frame_cnt), 0);

    // abort on the last GAP cycle: completion suppressed, frame_cnt held at 1
    cfg(1, 1, 1, 0);
    kick();
    repeat (5) step();
    chk("tg pre phase", 32'(phase), 3);
    chk("tg pre frame_cnt", 32'(frame_cnt), 1);
    chk("tg pre fdone", 32'(frame_done), 1);
    abort = 1'b1;
    #1;
    chk("tg abort fdone", 32'(frame_done), 0);
    step();
    abort = 1'b0;
    check_idle("tg post");
    chk("tg post frame_cnt", 32'(frame_cnt), 1);

    // 4: mid-EXPOSE cfg change and start are ignored (3 frames of 6 cycles)
    cfg(3, 2, 1, 3);
    kick();
    for (int k = 1; k <= 19; k++) begin
      m = (k - 1) % 6;
      exp_ph = (k == 19) ? 0 : (m < 3) ? 1 : (m < 5) ? 2 : 3;
      exp_pc = (k == 19) ? 0 : (m < 3) ? m : (m < 5) ? m - 3 : 0;
      chk($sformatf("t4 phase c%0d", k), 32'(phase), 32'(exp_ph));
      chk($sformatf("t4 phase_cnt c%0d", k), 32'(phase_cnt), 32'(exp_pc));
      chk($sformatf("t4 frame_cnt c%0d", k), 32'(frame_cnt), 32'((k - 1) / 6));
      chk($sformatf("t4 sdone c%0d", k), 32'(seq_done), (k == 18) ? 1 : 0);
      if (k == 2) begin
        cfg_expose = CNT_W'(10);
        start = 1'b1;
        step();
        start = 1'b0;
      end else if (k < 19) begin
        step();
      end
    end

    // 5: continuous, 256 frames of 3 cycles, frame_cnt wraps
    cfg(1, 1, 1, 0);
    kick();
    fd_count  = 0;
    busy_drop = 0;
    fc_last   = -1;
    for (int k = 1; k <= 768; k++) begin
      if (frame_done) fd_count++;
      if (!busy) busy_drop++;
      if (k == 768) fc_last = int'(frame_cnt);
      step();
    end
    chk("t5 frame_done count", 32'(fd_count), 256);
    chk("t5 busy drops", 32'(busy_drop), 0);
    chk("t5 frame_cnt max", 32'(fc_last), 255);
    chk("t5 frame_cnt wrapped", 32'(frame_cnt), 0);
    chk("t5 phase after wrap", 32'(phase), 1);
    chk("t5 busy after wrap", 32'(busy), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("t5 abort");

    // 6: async reset mid-GAP with frame_cnt=2
    cfg(1, 1, 1, 0);
    kick();
    repeat (8) step();
    chk("t6 pre phase", 32'(phase), 3);
    chk("t6 pre frame_cnt", 32'(frame_cnt), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t6 reset");
    chk("t6 reset frame_cnt", 32'(frame_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_zero_cfg("t6 after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
